// File: rtl/ccu_ctrl_snoop_collector.sv
// Snoop collector: gathers CR responses from the snooped ports, forwards the first
// data responder's CD beats into the memory unit's CD FIFO and drains all other CD.
module ccu_ctrl_snoop_collector #(
  parameter int NoMstPorts      = 4,
  parameter int AxiDataWidth    = 64,
  parameter int DcacheLineWidth = 128,
  localparam int MstIdxBits     = $clog2(NoMstPorts)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_valid_i,
  output logic                                 start_ready_o,
  input  logic [NoMstPorts-1:0]                snoop_mask_i,
  input  logic [NoMstPorts-1:0]                cr_valid_i,
  input  logic [NoMstPorts*5-1:0]              cr_resp_i,
  output logic [NoMstPorts-1:0]                cr_ready_o,
  input  logic [NoMstPorts-1:0]                cd_valid_i,
  input  logic [NoMstPorts*AxiDataWidth-1:0]   cd_data_i,
  input  logic [NoMstPorts-1:0]                cd_last_i,
  output logic [NoMstPorts-1:0]                cd_ready_o,
  output logic [AxiDataWidth-1:0]              cd_data_o,
  output logic                                 cd_handshake_o,
  input  logic                                 cd_fifo_full_i,
  output logic                                 done_valid_o,
  input  logic                                 done_ready_i,
  output logic                                 data_available_o,
  output logic [MstIdxBits-1:0]                first_responder_o,
  output logic                                 pass_dirty_o,
  output logic                                 is_shared_o,
  output logic                                 error_o
);
  localparam int Beats = DcacheLineWidth / AxiDataWidth;
  localparam int CntW  = (Beats > 1) ? $clog2(Beats) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT_CR = 2'd1;
  localparam logic [1:0] FWD_CD  = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]                       state_q, state_d;
  logic [NoMstPorts-1:0]            pending_cr_q, drain_pend_q, drain_pend_d;
  logic [NoMstPorts-1:0][CntW-1:0]  beat_cnt_q;
  logic                             chosen_q;
  logic [MstIdxBits-1:0]            first_q;
  logic                             pass_dirty_q, is_shared_q, error_q;

  logic [NoMstPorts-1:0] dt_vec, err_vec, pd_vec, sh_vec, wu_vec;
  logic [NoMstPorts-1:0] cr_hs, cd_hs, beat_last;
  logic                  cd_active, new_found, last_err, unused_was_unique;
  logic [MstIdxBits-1:0] new_first;

  for (genvar g = 0; g < NoMstPorts; g++) begin : g_port
    assign dt_vec[g]    = cr_resp_i[5*g];
    assign err_vec[g]   = cr_resp_i[5*g+1];
    assign pd_vec[g]    = cr_resp_i[5*g+2];
    assign sh_vec[g]    = cr_resp_i[5*g+3];
    assign wu_vec[g]    = cr_resp_i[5*g+4];
    assign beat_last[g] = (beat_cnt_q[g] == CntW'(Beats-1));
  end
  assign unused_was_unique = ^wu_vec;

  // CD is accepted in WAIT_CR as well, so data may overlap the remaining CRs.
  assign cd_active = (state_q == WAIT_CR) || (state_q == FWD_CD);

  always_comb begin
    cr_ready_o = (state_q == WAIT_CR) ? pending_cr_q : '0;
    cd_ready_o = '0;
    for (int i = 0; i < NoMstPorts; i++)
      if (cd_active && drain_pend_q[i])
        cd_ready_o[i] = (chosen_q && first_q == MstIdxBits'(i)) ? !cd_fifo_full_i : 1'b1;
  end

  assign cr_hs          = cr_valid_i & cr_ready_o;
  assign cd_hs          = cd_valid_i & cd_ready_o;
  assign cd_handshake_o = chosen_q & cd_hs[first_q];
  assign cd_data_o      = cd_active ? cd_data_i[AxiDataWidth*first_q +: AxiDataWidth] : '0;

  // Downward scan so the lowest-index same-cycle data responder wins.
  always_comb begin
    new_found = 1'b0;
    new_first = '0;
    for (int i = NoMstPorts-1; i >= 0; i--)
      if (cr_hs[i] && dt_vec[i]) begin
        new_found = 1'b1;
        new_first = MstIdxBits'(i);
      end
  end

  always_comb begin
    last_err = 1'b0;
    for (int i = 0; i < NoMstPorts; i++)
      if (cd_hs[i] && (cd_last_i[i] != beat_last[i])) last_err = 1'b1;
  end

  assign drain_pend_d = (drain_pend_q | (cr_hs & dt_vec)) & ~(cd_hs & beat_last);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid_i) state_d = (snoop_mask_i == '0) ? DONE : WAIT_CR;
      WAIT_CR: if (pending_cr_q == '0) state_d = chosen_q ? FWD_CD : DONE;
      FWD_CD:  if (drain_pend_q == '0) state_d = DONE;
      default: if (done_ready_i) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      pending_cr_q <= '0;
      drain_pend_q <= '0;
      beat_cnt_q   <= '0;
      chosen_q     <= 1'b0;
      first_q      <= '0;
      pass_dirty_q <= 1'b0;
      is_shared_q  <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        beat_cnt_q <= '0;
        if (start_valid_i) begin
          pending_cr_q <= snoop_mask_i;
          drain_pend_q <= '0;
          chosen_q     <= 1'b0;
          first_q      <= '0;
          pass_dirty_q <= 1'b0;
          is_shared_q  <= 1'b0;
          error_q      <= 1'b0;
        end
      end else begin
        pending_cr_q <= pending_cr_q & ~cr_hs;
        drain_pend_q <= drain_pend_d;
        for (int i = 0; i < NoMstPorts; i++)
          if (cd_hs[i]) beat_cnt_q[i] <= beat_last[i] ? '0 : beat_cnt_q[i] + CntW'(1);
        if (!chosen_q && new_found) begin
          chosen_q <= 1'b1;
          first_q  <= new_first;
        end
        pass_dirty_q <= pass_dirty_q | (|(cr_hs & pd_vec));
        is_shared_q  <= is_shared_q  | (|(cr_hs & sh_vec));
        error_q      <= error_q | (|(cr_hs & err_vec)) | last_err;
      end
    end
  end

  assign start_ready_o     = (state_q == IDLE);
  assign done_valid_o      = (state_q == DONE);
  assign data_available_o  = chosen_q;
  assign first_responder_o = first_q;
  assign pass_dirty_o      = pass_dirty_q;
  assign is_shared_o       = is_shared_q;
  assign error_o           = error_q;
endmodule

// File: tb/tb_ccu_ctrl_snoop_collector.sv
// Bench for the snoop collector: directed scenarios plus random transactions checked
// against a transaction-level model of the expected merge result and forwarded beats.
module tb_ccu_ctrl_snoop_collector;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid, start_ready;
  logic [3:0]  snoop_mask, cr_valid, cr_ready, cd_valid, cd_last, cd_ready;
  logic [19:0] cr_resp;
  logic [255:0] cd_data;
  logic [63:0] cd_data_out;
  logic        cd_hs_out, cd_full, done_valid, done_ready;
  logic        data_avail, pass_dirty, is_shared, err;
  logic [1:0]  first_resp;

  int n_asrt = 0;
  int n_fail = 0;

  logic [3:0]  t_mask;
  int          t_dly[4];
  logic [4:0]  t_resp[4];
  logic [63:0] t_data[4][2];
  logic        t_last[4][2];
  bit          t_rfull, t_rst;
  int          t_ffrom, t_flen, t_dwait;

  ccu_ctrl_snoop_collector dut (
    .clk_i(clk), .rst_i(rst),
    .start_valid_i(start_valid), .start_ready_o(start_ready), .snoop_mask_i(snoop_mask),
    .cr_valid_i(cr_valid), .cr_resp_i(cr_resp), .cr_ready_o(cr_ready),
    .cd_valid_i(cd_valid), .cd_data_i(cd_data), .cd_last_i(cd_last), .cd_ready_o(cd_ready),
    .cd_data_o(cd_data_out), .cd_handshake_o(cd_hs_out), .cd_fifo_full_i(cd_full),
    .done_valid_o(done_valid), .done_ready_i(done_ready),
    .data_available_o(data_avail), .first_responder_o(first_resp),
    .pass_dirty_o(pass_dirty), .is_shared_o(is_shared), .error_o(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic zero_inputs();
    start_valid = 1'b0; snoop_mask = '0; cr_valid = '0; cr_resp = '0;
    cd_valid = '0; cd_data = '0; cd_last = '0; cd_full = 1'b0; done_ready = 1'b0;
  endtask

  task automatic set_clean(input logic [3:0] mask);
    t_mask = mask; t_rfull = 1'b0; t_rst = 1'b0; t_ffrom = 0; t_flen = 0; t_dwait = 0;
    for (int i = 0; i < 4; i++) begin
      t_dly[i] = i + 1; t_resp[i] = '0;
      t_data[i][0] = 64'h100 * (i + 1); t_data[i][1] = 64'h100 * (i + 1) + 64'h1;
      t_last[i][0] = 1'b0; t_last[i][1] = 1'b1;
    end
  endtask

  task automatic run_txn();
    int exp_first, best, exp_cnt, cyc, pushes;
    bit exp_pd, exp_sh, exp_err, done_seen, full;
    logic [63:0] exp_q[$];
    int cr_at[4], beat[4], gap[4];
    // expected result: earliest data CR wins, ties to the lowest port
    exp_first = -1; best = 1000; exp_pd = 0; exp_sh = 0; exp_err = 0;
    for (int i = 0; i < 4; i++) begin
      cr_at[i] = -1; beat[i] = 0; gap[i] = 0;
      if (t_mask[i]) begin
        exp_pd |= t_resp[i][2]; exp_sh |= t_resp[i][3]; exp_err |= t_resp[i][1];
        if (t_resp[i][0]) begin
          for (int b = 0; b < 2; b++) if (t_last[i][b] != (b == 1)) exp_err = 1;
          if (t_dly[i] < best) begin best = t_dly[i]; exp_first = i; end
        end
      end
    end
    if (exp_first >= 0) for (int b = 0; b < 2; b++) exp_q.push_back(t_data[exp_first][b]);
    exp_cnt = exp_q.size();

    @(posedge clk); #1;
    chk("start_ready_idle", 64'(start_ready), 64'd1);
    start_valid = 1'b1; snoop_mask = t_mask;
    @(posedge clk); #1;
    start_valid = 1'b0; snoop_mask = '0;
    done_seen = 0; pushes = 0; cyc = 1;
    while (!done_seen && cyc < 300) begin
      cr_valid = '0; cr_resp = '0; cd_valid = '0; cd_data = '0; cd_last = '0;
      for (int i = 0; i < 4; i++) begin
        if (t_mask[i] && cr_at[i] < 0 && cyc >= t_dly[i]) begin
          cr_valid[i] = 1'b1; cr_resp[5*i +: 5] = t_resp[i];
        end else if (!t_mask[i] && t_rfull) begin
          cr_valid[i] = 1'($urandom % 2);
        end
        if (t_mask[i] && t_resp[i][0] && cr_at[i] >= 0 && beat[i] < 2) begin
          if (gap[i] > 0) gap[i]--;
          else begin
            cd_valid[i] = 1'b1; cd_data[64*i +: 64] = t_data[i][beat[i]];
            cd_last[i] = t_last[i][beat[i]];
          end
        end
      end
      full = t_rfull ? ($urandom % 3 == 0) : (cyc >= t_ffrom && cyc < t_ffrom + t_flen);
      cd_full = full;
      #1;
      if (done_valid) done_seen = 1;
      else begin
        chk("cr_ready_unmasked", 64'(cr_ready & ~t_mask), 64'd0);
        if (full) chk("push_while_full", 64'(cd_hs_out), 64'd0);
        if (full && exp_first >= 0) chk("sel_ready_while_full", 64'(cd_ready[exp_first]), 64'd0);
        if (cd_hs_out) begin
          pushes++;
          chk("push_count_bound", 64'(pushes <= exp_cnt), 64'd1);
          if (exp_q.size() > 0) chk("cd_data", cd_data_out, exp_q.pop_front());
        end
        for (int i = 0; i < 4; i++) begin
          if (cr_valid[i] && cr_ready[i] && t_mask[i]) cr_at[i] = cyc;
          if (cd_valid[i] && cd_ready[i]) begin
            beat[i]++; gap[i] = t_rfull ? int'($urandom % 3) : 0;
          end
        end
        if (t_rst && pushes == 1) begin
          zero_inputs();
          #1 rst = 1'b1;
          #1;
          chk("rst_start_ready", 64'(start_ready), 64'd1);
          chk("rst_cd_ready", 64'(cd_ready), 64'd0);
          chk("rst_cr_ready", 64'(cr_ready), 64'd0);
          chk("rst_done_valid", 64'(done_valid), 64'd0);
          chk("rst_cd_handshake", 64'(cd_hs_out), 64'd0);
          @(posedge clk); #1 rst = 1'b0;
          return;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    zero_inputs();
    chk("done_reached", 64'(done_seen), 64'd1);
    if (!done_seen) begin
      rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
      return;
    end
    chk("all_beats_pushed", 64'(exp_q.size()), 64'd0);
    chk("data_available", 64'(data_avail), 64'(exp_first >= 0));
    chk("first_responder", 64'(first_resp), 64'((exp_first >= 0) ? exp_first : 0));
    chk("pass_dirty", 64'(pass_dirty), 64'(exp_pd));
    chk("is_shared", 64'(is_shared), 64'(exp_sh));
    chk("error", 64'(err), 64'(exp_err));
    chk("start_ready_busy", 64'(start_ready), 64'd0);
    for (int k = 0; k < t_dwait; k++) begin
      @(posedge clk); #1;
      chk("done_hold", 64'(done_valid), 64'd1);
      chk("done_hold_result", 64'({data_avail, first_resp, pass_dirty, is_shared, err}),
          64'({exp_first >= 0, 2'((exp_first >= 0) ? exp_first : 0), exp_pd, exp_sh, exp_err}));
    end
    done_ready = 1'b1;
    @(posedge clk); #1;
    done_ready = 1'b0;
    chk("idle_after_done", 64'(start_ready), 64'd1);
    chk("done_dropped", 64'(done_valid), 64'd0);
  endtask

  initial begin
    zero_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_start_ready", 64'(start_ready), 64'd1);
    chk("reset_done_valid", 64'(done_valid), 64'd0);
    chk("reset_readies", 64'({cr_ready, cd_ready}), 64'd0);
    chk("reset_results", 64'({cd_hs_out, data_avail, first_resp, pass_dirty, is_shared, err}), 64'd0);
    rst = 1'b0;

    // basic forward from port 2
    set_clean(4'b0110);
    t_dly[1] = 2; t_dly[2] = 3; t_resp[2] = 5'b00101;
    t_data[2][0] = 64'hA; t_data[2][1] = 64'hB;
    run_txn();

    // same-cycle data responders: port 1 wins, port 3 drained
    set_clean(4'b1010);
    t_dly[1] = 2; t_dly[3] = 2; t_resp[1] = 5'b00001; t_resp[3] = 5'b00001;
    run_txn();

    // FIFO full for 3 cycles between the two beats
    set_clean(4'b0110);
    t_dly[1] = 2; t_dly[2] = 3; t_resp[2] = 5'b00101;
    t_data[2][0] = 64'hA; t_data[2][1] = 64'hB; t_ffrom = 5; t_flen = 3;
    run_txn();

    // no data: done held until accepted
    set_clean(4'b0001);
    t_resp[0] = 5'b01000; t_dwait = 4;
    run_txn();

    // early last on beat 0
    set_clean(4'b0100);
    t_resp[2] = 5'b00001; t_last[2][0] = 1'b1;
    run_txn();

    // empty mask
    set_clean(4'b0000);
    run_txn();

    // reset after the first forwarded beat, then a fresh transaction
    set_clean(4'b0110);
    t_dly[1] = 2; t_dly[2] = 3; t_resp[2] = 5'b00101;
    t_data[2][0] = 64'hA; t_data[2][1] = 64'hB; t_rst = 1'b1;
    run_txn();
    t_rst = 1'b0;
    run_txn();

    for (int n = 0; n < 25; n++) begin
      set_clean(4'($urandom % 16));
      t_rfull = 1'b1; t_dwait = int'($urandom % 4);
      for (int i = 0; i < 4; i++) begin
        t_dly[i] = 1 + int'($urandom % 6);
        t_resp[i] = 5'($urandom % 32);
        t_data[i][0] = {$urandom, $urandom};
        t_data[i][1] = {$urandom, $urandom};
        for (int b = 0; b < 2; b++) t_last[i][b] = (b == 1) ^ ($urandom % 8 == 0);
      end
      run_txn();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
